// File: rtl/pmem_arb_pkg.sv
// rtl/pmem_arb_pkg.sv - shared state encoding, master IDs and default widths for the PMEM arbiter
package pmem_arb_pkg;

  // Arbiter FSM states; encoding is shared with anything that decodes the state
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  // Master identifiers as carried by the owner and RR pointer bits
  localparam logic MST_IFU = 1'b0;
  localparam logic MST_LSU = 1'b1;

  // Default widths of the PMEM request fields
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int MASK_W_DEF = 8;

endpackage

// File: rtl/pmem_arb_pick.sv
// rtl/pmem_arb_pick.sv - combinational winner select (round-robin when PMEM_ARBITER_RR_EN is defined)
module pmem_arb_pick
  import pmem_arb_pkg::*;
(
  input  logic m0_valid,
  input  logic m1_valid,
  input  logic ptr,
  output logic winner,
  output logic any
);

  assign any = m0_valid | m1_valid;

`ifdef PMEM_ARBITER_RR_EN
  // Tie goes to the master named by the pointer; a lone requester always wins
  always_comb begin
    winner = MST_IFU;
    if (m0_valid && m1_valid) begin
      winner = ptr;
    end else if (m1_valid) begin
      winner = MST_LSU;
    end
  end
`else
  // Pointer is not used in the fixed-priority build
  logic unused_ptr;
  assign unused_ptr = ptr;

  // Fixed priority: the LSU wins whenever it requests
  always_comb begin
    winner = MST_IFU;
    if (m1_valid) begin
      winner = MST_LSU;
    end
  end
`endif

endmodule

// File: rtl/pmem_arbiter.sv
// rtl/pmem_arbiter.sv - two-master PMEM arbiter, one outstanding transaction (optional PMEM_ARBITER_RR_EN)
module pmem_arbiter
  import pmem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int MASK_W = MASK_W_DEF
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              m0_req_valid,
  output logic              m0_req_ready,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic              m0_wen,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [MASK_W-1:0] m0_wmask,
  output logic              m0_resp_valid,
  output logic [DATA_W-1:0] m0_rdata,

  input  logic              m1_req_valid,
  output logic              m1_req_ready,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic              m1_wen,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [MASK_W-1:0] m1_wmask,
  output logic              m1_resp_valid,
  output logic [DATA_W-1:0] m1_rdata,

  output logic              s_req_valid,
  input  logic              s_req_ready,
  output logic [ADDR_W-1:0] s_addr,
  output logic              s_wen,
  output logic [DATA_W-1:0] s_wdata,
  output logic [MASK_W-1:0] s_wmask,
  input  logic              s_resp_valid,
  input  logic [DATA_W-1:0] s_rdata
);

  arb_state_t        state;
  logic              owner;
  logic [DATA_W-1:0] rdata_q;
  logic              ptr;
  logic              win;
  logic              any_req;
  logic              grant;

  pmem_arb_pick u_pick (
    .m0_valid (m0_req_valid),
    .m1_valid (m1_req_valid),
    .ptr      (ptr),
    .winner   (win),
    .any      (any_req)
  );

  // A grant only happens in IDLE; rst gating keeps ready low throughout reset
  assign grant        = rst && (state == IDLE) && any_req;
  assign m0_req_ready = grant && (win == MST_IFU);
  assign m1_req_ready = grant && (win == MST_LSU);

  // Response data is only presented alongside its valid pulse
  assign m0_rdata = m0_resp_valid ? rdata_q : '0;
  assign m1_rdata = m1_resp_valid ? rdata_q : '0;

`ifdef PMEM_ARBITER_RR_EN
  // After each grant, prefer the master that lost it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= MST_IFU;
    end else if (grant) begin
      ptr <= ~win;
    end
  end
`else
  assign ptr = MST_IFU;
`endif

  // Transaction FSM: latch winner, issue downstream, wait for reply, pulse owner
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      owner         <= MST_IFU;
      s_req_valid   <= 1'b0;
      s_addr        <= '0;
      s_wen         <= 1'b0;
      s_wdata       <= '0;
      s_wmask       <= '0;
      rdata_q       <= '0;
      m0_resp_valid <= 1'b0;
      m1_resp_valid <= 1'b0;
    end else begin
      m0_resp_valid <= 1'b0;
      m1_resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            owner       <= win;
            s_req_valid <= 1'b1;
            if (win == MST_LSU) begin
              s_addr  <= m1_addr;
              s_wen   <= m1_wen;
              s_wdata <= m1_wdata;
              s_wmask <= m1_wmask;
            end else begin
              s_addr  <= m0_addr;
              s_wen   <= m0_wen;
              s_wdata <= m0_wdata;
              s_wmask <= m0_wmask;
            end
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (s_req_ready) begin
            s_req_valid <= 1'b0;
            state       <= WAIT;
          end
        end
        WAIT: begin
          if (s_resp_valid) begin
            rdata_q       <= s_rdata;
            m0_resp_valid <= (owner == MST_IFU);
            m1_resp_valid <= (owner == MST_LSU);
            state         <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pmem_arbiter.sv
// tb/tb_pmem_arbiter.sv - self-checking bench for pmem_arbiter with a transaction-level reference model
module tb_pmem_arbiter;

  logic        clk;
  logic        rst;
  logic        m0_req_valid, m0_req_ready, m0_wen, m0_resp_valid;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic [7:0]  m0_wmask;
  logic        m1_req_valid, m1_req_ready, m1_wen, m1_resp_valid;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [7:0]  m1_wmask;
  logic        s_req_valid, s_req_ready, s_wen, s_resp_valid;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [7:0]  s_wmask;

  int total = 0;
  int bad   = 0;

  pmem_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_addr(m0_addr),
    .m0_wen(m0_wen), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask),
    .m0_resp_valid(m0_resp_valid), .m0_rdata(m0_rdata),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_addr(m1_addr),
    .m1_wen(m1_wen), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask),
    .m1_resp_valid(m1_resp_valid), .m1_rdata(m1_rdata),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_addr(s_addr),
    .s_wen(s_wen), .s_wdata(s_wdata), .s_wmask(s_wmask),
    .s_resp_valid(s_resp_valid), .s_rdata(s_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one transaction at a time, tracked as grant -> issued -> replied -> delivered
  logic        busy, issued, awaiting, resp_now, own, pref, acc0, acc1;
  logic [31:0] t_addr, t_wdata, exp_rd;
  logic        t_wen;
  logic [7:0]  t_wmask;
  logic        grant_hist[$];
  int          resp0_cnt = 0;
  int          resp1_cnt = 0;

  function automatic logic pref_after_reset();
`ifdef PMEM_ARBITER_RR_EN
    return 1'b0;
`else
    return 1'b1;
`endif
  endfunction

  initial begin
    logic exp_r0, exp_r1, exp_sv, rv0, rv1;
    busy = 0; issued = 0; awaiting = 0; resp_now = 0; own = 0;
    pref = pref_after_reset(); acc0 = 0; acc1 = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("rst_outs", {m0_req_ready, m1_req_ready, s_req_valid, s_wen, m0_resp_valid,
                           m1_resp_valid, |s_addr, |s_wdata, |s_wmask, |m0_rdata, |m1_rdata}, 0);
        busy = 0; issued = 0; awaiting = 0; resp_now = 0; acc0 = 0; acc1 = 0;
        pref = pref_after_reset();
      end else begin
        exp_r0 = !busy && m0_req_valid && !(m1_req_valid && pref == 1'b1);
        exp_r1 = !busy && m1_req_valid && !(m0_req_valid && pref == 1'b0);
        check("ready0", m0_req_ready, exp_r0);
        check("ready1", m1_req_ready, exp_r1);
        exp_sv = busy && !issued;
        check("s_valid", s_req_valid, exp_sv);
        if (exp_sv) begin
          check("s_addr", s_addr, t_addr);
          check("s_wdata", s_wdata, t_wdata);
          check("s_wen_mask", {s_wen, s_wmask}, {t_wen, t_wmask});
        end
        rv0 = resp_now && own == 1'b0;
        rv1 = resp_now && own == 1'b1;
        check("resp0", m0_resp_valid, rv0);
        check("resp1", m1_resp_valid, rv1);
        check("rdata0", m0_rdata, rv0 ? exp_rd : 32'h0);
        check("rdata1", m1_rdata, rv1 ? exp_rd : 32'h0);
        if (m0_resp_valid) resp0_cnt++;
        if (m1_resp_valid) resp1_cnt++;
        acc0 = m0_req_ready;
        acc1 = m1_req_ready;
        if (resp_now) begin
          busy = 0;
          resp_now = 0;
        end else if (awaiting && s_resp_valid) begin
          exp_rd = s_rdata;
          awaiting = 0;
          resp_now = 1;
        end
        if (exp_sv && s_req_ready) begin
          issued = 1;
          awaiting = 1;
        end
        if (exp_r0 || exp_r1) begin
          busy = 1; issued = 0; own = exp_r1;
          t_addr  = own ? m1_addr  : m0_addr;
          t_wdata = own ? m1_wdata : m0_wdata;
          t_wen   = own ? m1_wen   : m0_wen;
          t_wmask = own ? m1_wmask : m0_wmask;
`ifdef PMEM_ARBITER_RR_EN
          pref = ~own;
`endif
          grant_hist.push_back(own);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic new_req(input int m);
    if (m == 0) begin
      m0_req_valid = 1; m0_addr = $urandom & 32'hFFFF_FFFC; m0_wen = $urandom_range(0, 1);
      m0_wdata = $urandom; m0_wmask = $urandom;
    end else begin
      m1_req_valid = 1; m1_addr = $urandom & 32'hFFFF_FFFC; m1_wen = $urandom_range(0, 1);
      m1_wdata = $urandom; m1_wmask = $urandom;
    end
  endtask

  task automatic idle_inputs();
    m0_req_valid = 0; m0_addr = 0; m0_wen = 0; m0_wdata = 0; m0_wmask = 0;
    m1_req_valid = 0; m1_addr = 0; m1_wen = 0; m1_wdata = 0; m1_wmask = 0;
    s_req_ready = 0; s_resp_valid = 0; s_rdata = 0;
  endtask

  task automatic do_reset();
    rst = 0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1;
  endtask

  task automatic random_phase(input int n);
    for (int c = 0; c < n; c++) begin
      tick();
      if (acc0 || !m0_req_valid) begin
        if ($urandom_range(0, 9) < 6) new_req(0); else m0_req_valid = 0;
      end else if ($urandom_range(0, 9) == 0) m0_req_valid = 0;
      if (acc1 || !m1_req_valid) begin
        if ($urandom_range(0, 9) < 6) new_req(1); else m1_req_valid = 0;
      end else if ($urandom_range(0, 9) == 0) m1_req_valid = 0;
      s_req_ready  = ($urandom_range(0, 3) != 0);
      s_resp_valid = awaiting ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      s_rdata      = $urandom;
    end
  endtask

  task automatic contend(input logic e0, input logic e1, input logic e2, input logic e3);
    int   c0, c1;
    logic eo[4];
    eo[0] = e0; eo[1] = e1; eo[2] = e2; eo[3] = e3;
    c0 = 0; c1 = 0;
    grant_hist.delete();
    new_req(0);
    new_req(1);
    s_req_ready = 1;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (acc0) begin c0++; if (c0 < 2) new_req(0); else m0_req_valid = 0; end
      if (acc1) begin c1++; if (c1 < 2) new_req(1); else m1_req_valid = 0; end
      s_resp_valid = awaiting;
      s_rdata = $urandom;
    end
    check("n_grants", grant_hist.size(), 4);
    for (int k = 0; k < 4; k++) begin
      if (k < grant_hist.size()) check($sformatf("order%0d", k), grant_hist[k], eo[k]);
    end
    idle_inputs();
  endtask

  initial begin
    int snap;
    rst = 0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1 rst = 1;

    // Reset while a read is waiting for its response
    m0_req_valid = 1; m0_addr = 32'h8000_0000; s_req_ready = 1;
    tick(); m0_req_valid = 0;
    tick(); s_req_ready = 0;
    tick();
    rst = 0; m0_req_valid = 1; m1_req_valid = 1;
    tick();
    tick(); rst = 1; m0_req_valid = 0; m1_req_valid = 0; s_resp_valid = 1; s_rdata = 32'h5555_AAAA;
    tick(); s_resp_valid = 0;
    @(negedge clk); check("late_resp", m0_resp_valid, 0);
    tick(); m0_req_valid = 1; m0_addr = 32'h8000_0010;
    @(negedge clk); check("idle_after_rst", m0_req_ready, 1);
    tick(); m0_req_valid = 0; s_req_ready = 1;
    tick(); s_req_ready = 0; s_resp_valid = 1;
    tick(); s_resp_valid = 0;
    repeat (2) tick();

    // Single IFU load at minimum latency
    m0_req_valid = 1; m0_addr = 32'h8000_0004; m0_wen = 0; s_req_ready = 1;
    @(negedge clk); check("ld_grant", m0_req_ready, 1);
    tick(); m0_req_valid = 0;
    @(negedge clk);
    check("ld_s_valid", s_req_valid, 1);
    check("ld_s_addr", s_addr, 32'h8000_0004);
    check("ld_s_wen", s_wen, 0);
    tick(); s_req_ready = 0; s_resp_valid = 1; s_rdata = 32'h0000_0513;
    tick(); s_resp_valid = 0; s_rdata = 32'h0;
    @(negedge clk);
    check("ld_resp", m0_resp_valid, 1);
    check("ld_rdata", m0_rdata, 32'h0000_0513);
    check("ld_no_m1", m1_resp_valid, 0);
    repeat (2) tick();

    // LSU store held off by PMEM for three cycles
    snap = resp1_cnt;
    m1_req_valid = 1; m1_wen = 1; m1_addr = 32'h8000_1000; m1_wdata = 32'hDEAD_BEEF; m1_wmask = 8'h0F;
    @(negedge clk); check("st_grant", m1_req_ready, 1);
    tick(); m1_req_valid = 0; m1_wdata = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) s_req_ready = 1;
      @(negedge clk);
      check("st_hold", {s_req_valid, s_wen, s_addr, s_wmask, s_wdata},
            {1'b1, 1'b1, 32'h8000_1000, 8'h0F, 32'hDEAD_BEEF});
      tick();
    end
    s_req_ready = 0; s_resp_valid = 1; s_rdata = $urandom;
    tick(); s_resp_valid = 0;
    repeat (4) tick();
    check("st_one_pulse", resp1_cnt - snap, 1);

    // Spurious responses in IDLE and ISSUE
    snap = resp0_cnt;
    s_resp_valid = 1;
    tick(); s_resp_valid = 0; m0_req_valid = 1; m0_wen = 0; m0_addr = 32'h8000_0008;
    tick(); m0_req_valid = 0; s_resp_valid = 1;
    tick(); s_resp_valid = 0; s_req_ready = 1;
    tick(); s_req_ready = 0;
    check("spur_none", resp0_cnt - snap, 0);
    tick(); s_resp_valid = 1; s_rdata = 32'h0000_1234;
    tick(); s_resp_valid = 0;
    @(negedge clk);
    check("spur_resp", m0_resp_valid, 1);
    check("spur_rdata", m0_rdata, 32'h0000_1234);
    repeat (2) tick();
    check("spur_one_pulse", resp0_cnt - snap, 1);

    // Simultaneous requests, two per master, from a fresh reset
    do_reset();
`ifdef PMEM_ARBITER_RR_EN
    contend(1'b0, 1'b1, 1'b0, 1'b1);
`else
    contend(1'b1, 1'b1, 1'b0, 1'b0);
`endif

    // Randomized traffic against the reference model
    random_phase(3000);
    idle_inputs();
    repeat (8) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
